// File: rtl/rr_grant_tracker_pkg.sv
// Shared types and helpers for the round-robin grant tracker.
// Holds the tracker state encoding and the hold-counter sizing function.
package rr_grant_tracker_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The hold counter must represent 0..max_hold; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int max_hold);
        return (max_hold < 2) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotates req so ptr lands at bit 0, finds the lowest set bit, then rotates back.
module rr_priority_pick #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    localparam logic [IDX_W:0] WIDTH_EXT = (IDX_W + 1)'(WIDTH);

    logic [2*WIDTH-1:0] rot_dbl;
    logic [WIDTH-1:0]   rot;
    logic [IDX_W-1:0]   first;
    logic [IDX_W:0]     sum;
    logic [WIDTH-1:0]   oh_rot;
    logic [2*WIDTH-1:0] oh_dbl;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rot_dbl = {req, req} >> ptr;
        rot     = rot_dbl[WIDTH-1:0];
        hit     = |rot;

        first = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (rot[k]) first = IDX_W'(k);
        end

        // Rotated offset back to an absolute index: compare-and-wrap instead of modulo.
        sum = {1'b0, ptr} + {1'b0, first};
        if (sum >= WIDTH_EXT) sum = sum - WIDTH_EXT;
        idx = sum[IDX_W-1:0];

        oh_rot        = '0;
        oh_rot[first] = hit;
        oh_dbl        = {oh_rot, oh_rot} << ptr;
        onehot        = oh_dbl[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/rr_grant_tracker.sv
// Round-robin arbitration stage: registers a one-hot grant, holds it until done or
// hold timeout, and rotates priority to one past the last owner on every release.
module rr_grant_tracker
    import rr_grant_tracker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int INIT_PTR = 2,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam int               CNT_W     = cnt_width(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] INIT_IDX  = IDX_W'(INIT_PTR);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             granted;
    logic             expire;
    logic             release_ev;
    logic [IDX_W-1:0] ptr_inc;
    logic [IDX_W-1:0] pick_ptr;
    logic             pick_hit;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_onehot;

    assign granted    = (state_q == ST_GRANT);
    assign expire     = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign release_ev = granted && (done || expire);
    assign timeout    = granted && expire && !done;

    assign ptr_inc  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    // A back-to-back re-pick must already see the rotated pointer.
    assign pick_ptr = release_ev ? ptr_inc : ptr_q;

    rr_priority_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .hit    (pick_hit),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en && pick_hit) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_ev) begin
                    ptr_d = ptr_inc;
                    if (en && pick_hit) begin
                        gnt_d = pick_onehot;
                        idx_d = pick_idx;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= INIT_IDX;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = idx_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_owner:   assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt[gnt_idx]);

endmodule

// File: tb/tb_rr_grant_tracker.sv
// Scoreboard bench: two trackers (timeout off / MAX_HOLD=4) share one stimulus stream
// and are compared each cycle against a queue-fed behavioural arbitration model.
module tb_rr_grant_tracker;

    localparam int W    = 4;
    localparam int IW   = 2;
    localparam int INIT = 2;

    typedef struct packed {
        logic [W-1:0]  gnt;
        logic          valid;
        logic [IW-1:0] idx;
        logic          tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, en, done;
    logic [W-1:0]  req;
    logic [W-1:0]  gnt [2];
    logic          gnt_valid [2];
    logic [IW-1:0] gnt_idx [2];
    logic          timeout [2];

    int   passed = 0;
    int   total  = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Model state per instance: owner -1 means idle.
    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    int m_last  [2];

    always #5 clk = ~clk;

    rr_grant_tracker #(.WIDTH(W), .INIT_PTR(INIT), .MAX_HOLD(0)) dut_free (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt[0]), .gnt_valid(gnt_valid[0]), .gnt_idx(gnt_idx[0]), .timeout(timeout[0])
    );

    rr_grant_tracker #(.WIDTH(W), .INIT_PTR(INIT), .MAX_HOLD(4)) dut_tmo (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt[1]), .gnt_valid(gnt_valid[1]), .gnt_idx(gnt_idx[1]), .timeout(timeout[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic int pick(input logic [W-1:0] r, input int p);
        for (int k = 0; k < W; k++) begin
            int i;
            i = (p + k) % W;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Expected outputs for the current cycle, then advance to the state after the edge.
    task automatic model_step(input int u, input int max_hold, output exp_t e);
        bit rel, tmo;
        if (!rst_n) begin
            e = '0;
            m_owner[u] = -1; m_held[u] = 0; m_ptr[u] = INIT; m_last[u] = 0;
            return;
        end
        tmo     = (m_owner[u] >= 0) && (max_hold != 0) && (m_held[u] == max_hold - 1) && !done;
        e.gnt   = (m_owner[u] >= 0) ? W'(1 << m_owner[u]) : '0;
        e.valid = (m_owner[u] >= 0);
        e.idx   = IW'(m_last[u]);
        e.tmo   = tmo;
        if (m_owner[u] < 0) begin
            if (en && req != 0) begin
                m_owner[u] = pick(req, m_ptr[u]); m_last[u] = m_owner[u]; m_held[u] = 0;
            end
        end else begin
            rel = done || ((max_hold != 0) && (m_held[u] == max_hold - 1));
            if (rel) begin
                m_ptr[u] = (m_owner[u] + 1) % W;
                if (en && req != 0) begin
                    m_owner[u] = pick(req, m_ptr[u]); m_last[u] = m_owner[u]; m_held[u] = 0;
                end else begin
                    m_owner[u] = -1;
                end
            end else begin
                m_held[u]++;
            end
        end
    endtask

    task automatic drive(input logic r_n, input logic e_n, input logic [W-1:0] rq, input logic d);
        exp_t e0, e1;
        @(negedge clk);
        rst_n = r_n; en = e_n; req = rq; done = d;
        model_step(0, 0, e0); exp_q0.push_back(e0);
        model_step(1, 4, e1); exp_q1.push_back(e1);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: pops one expectation per instance per cycle, well clear of the rising edge.
    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (exp_q0.size() > 0) begin
            mon_e = exp_q0.pop_front();
            check("free.gnt",     32'(gnt[0]),       32'(mon_e.gnt));
            check("free.valid",   32'(gnt_valid[0]), 32'(mon_e.valid));
            check("free.idx",     32'(gnt_idx[0]),   32'(mon_e.idx));
            check("free.timeout", 32'(timeout[0]),   32'(mon_e.tmo));
        end
        if (exp_q1.size() > 0) begin
            mon_e = exp_q1.pop_front();
            check("tmo.gnt",     32'(gnt[1]),       32'(mon_e.gnt));
            check("tmo.valid",   32'(gnt_valid[1]), 32'(mon_e.valid));
            check("tmo.idx",     32'(gnt_idx[1]),   32'(mon_e.idx));
            check("tmo.timeout", 32'(timeout[1]),   32'(mon_e.tmo));
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;
        do_reset();

        // Pointer start and wrap, then back-to-back re-pick.
        drive(1, 1, 4'b0011, 0);
        drive(1, 1, 4'b0011, 0);
        drive(1, 1, 4'b0011, 1);
        drive(1, 1, 4'b0011, 0);
        drive(1, 0, 4'b0000, 1);
        drive(1, 0, 4'b0000, 0);

        // Rotation fairness: done every third held cycle.
        do_reset();
        for (int i = 0; i < 16; i++) drive(1, 1, 4'b1111, (i > 0) && (i % 3 == 0));

        // Grant hold against req changes and en=0, release with en=0, then pointer check.
        do_reset();
        drive(1, 1, 4'b0100, 0);
        drive(1, 1, 4'b1011, 0);
        drive(1, 0, 4'b1011, 0);
        drive(1, 0, 4'b1011, 1);
        drive(1, 0, 4'b1001, 0);
        drive(1, 1, 4'b1001, 0);
        drive(1, 1, 4'b0000, 0);

        // Timeout expiry, then done coinciding with expiry.
        do_reset();
        drive(1, 1, 4'b0010, 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 4'b0000, 0);
        drive(1, 1, 4'b0010, 0);
        drive(1, 1, 4'b0000, 0);
        drive(1, 1, 4'b0000, 0);
        drive(1, 1, 4'b0000, 0);
        drive(1, 1, 4'b0000, 1);
        drive(1, 1, 4'b0000, 0);

        // Async reset mid-grant, then INIT_PTR restored.
        do_reset();
        drive(1, 1, 4'b1000, 0);
        drive(1, 1, 4'b1000, 0);
        drive(0, 1, 4'b1000, 0);
        drive(1, 1, 4'b1111, 0);
        drive(1, 1, 4'b1111, 0);

        // Self re-grant with only one requester.
        do_reset();
        drive(1, 1, 4'b1000, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 4'b1000, 1);
        drive(1, 1, 4'b0011, 1);
        drive(1, 1, 4'b0000, 0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(99) != 0, $urandom_range(3) != 0,
                  W'($urandom_range(15)), $urandom_range(9) < 3);
        end

        for (int i = 0; i < 10 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(negedge clk);
        #4;
        check("scoreboard_drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_grant_tracker.md
Name: rr_grant_tracker

Overview:
- Sequential arbitration stage that owns the round-robin pointer and holds grants across multi-cycle transactions.
- Samples a request vector and picks one requester, starting the search at the current pointer and wrapping around.
- Registers a one-hot grant and holds it until the owner signals done, or until a hold timeout expires.
- Advances the pointer to one past the last owner, so priority rotates fairly.

Parameters:
- WIDTH, 4, number of requesters; must be at least 2.
- INIT_PTR, 2, pointer value after reset; must be in 0..WIDTH-1.
- MAX_HOLD, 0, maximum number of cycles a grant may be held; 0 disables the timeout.
- IDX_W, $clog2(WIDTH), width of the pointer and index signals (derived, do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  enables new grants only; an existing grant is unaffected.
- req  in  WIDTH  per-requester request level.
- done  in  1  the current owner releases; sampled only while a grant is active.
- gnt  out  WIDTH  registered one-hot grant; all zeros when idle.
- gnt_valid  out  1  high when gnt is non-zero.
- gnt_idx  out  IDX_W  binary index of the owner; holds the last owner while idle.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - ptr=INIT_PTR, hold counter=0, state=IDLE.
- The selection function is combinational over req and ptr. It returns the first set bit at index ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1. A zero vector means no pick.
- IDLE:
  - If en=1 and req is non-zero, then at the next edge: gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, counter=0, state goes to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - done is ignored in IDLE.
- GRANT:
  - gnt is frozen and does not follow changes on req.
  - Dropping the owner's req does NOT release the grant; only done or timeout releases it.
  - The counter increments each cycle, saturating at MAX_HOLD.
- Release event: done=1, or (MAX_HOLD!=0 and counter==MAX_HOLD-1 with done=0).
  - On release, ptr takes (gnt_idx+1) mod WIDTH. Wrap: for gnt_idx=WIDTH-1, ptr becomes 0.
  - Back-to-back: on the same edge, if en=1 and req is non-zero, re-pick using the NEW ptr. Stay in GRANT with the new gnt and counter=0. No idle bubble.
  - The releasing requester wins the re-pick only if no other requester is asserting req.
  - Otherwise gnt=0, gnt_valid=0, state goes to IDLE.
- timeout pulses for exactly the release cycle when the release is caused by the counter.
  - If done and the expiry coincide, done wins and timeout stays 0.
- en=0 while in GRANT: the grant is held until release, and no re-pick is made.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt_valid equals |gnt.
  - gnt[gnt_idx]=1 whenever gnt_valid=1.
- Reset asserted mid-grant clears everything immediately (asynchronously), with no done required.

Decomposition:
- No shared package types are needed.
- Index math stays local: the mod-WIDTH increment is a compare-and-wrap, not a % operator.
- One combinational sub-module, rr_priority_pick, is natural.
  - Parameter: WIDTH.
  - Inputs: req, ptr.
  - Outputs: hit, idx, onehot.
  - Implementation: rotate req by ptr, do a fixed-priority find-first, then rotate back; the rotation is dynamic rather than a parameter.
- The pointer, counter and state flop live in rr_grant_tracker.

Test Plan (all with WIDTH=4, INIT_PTR=2 unless stated):
- Pointer start and wrap:
  - Stimulus: after reset, req=4'b0011, en=1.
  - Response: next cycle gnt=4'b0001, gnt_idx=0, because the search from 2 wraps to 0.
  - Then: done pulse with req still 4'b0011 gives gnt=4'b0010 on the same edge, with no bubble.
- Rotation fairness:
  - Stimulus: req=4'b1111 held, done pulsed every 3rd cycle.
  - Response: grant order idx 2,3,0,1,2; each grant is held exactly 3 cycles.
- Grant hold:
  - Stimulus: while gnt=4'b0100, change req to 4'b1011, and separately set en=0.
  - Response: gnt stays 4'b0100 until done.
  - Then: done with en=0 gives gnt=0 and gnt_valid=0 next cycle; ptr=3 is checked via the next pick with req=4'b1001, which yields idx 3.
- Timeout (MAX_HOLD=4):
  - Stimulus: grant to idx 1, done never asserted.
  - Response: timeout=1 on the 4th held cycle, then gnt released.
  - Variant: done in that same cycle gives timeout=0.
- Async reset mid-grant:
  - Stimulus: drop rst_n mid-cycle while gnt=4'b1000.
  - Response: gnt=0 immediately, without waiting for the clock.
  - Then: after release, req=4'b1111 gives idx 2 (INIT_PTR restored).
- Self re-grant:
  - Stimulus: only req[3] asserted, done pulsed.
  - Response: gnt stays 4'b1000 continuously, and ptr wraps to 0.
